// File: rtl/jtgng_ioctl_tx.sv
// jtgng_ioctl_tx: packs bytes from a valid/ready source into 16-bit ioctl_wr words.
// Define JTGNG_IOCTL_CSUM_EN to build the running word checksum on csum.
module jtgng_ioctl_tx #(
    parameter int AW     = 25,
    parameter int WR_GAP = 4
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          start,
    input  logic [AW-1:0] len,
    input  logic          abort,
    input  logic [7:0]    src_data,
    input  logic          src_valid,
    output logic          src_ready,
    output logic          ioctl_download,
    output logic          ioctl_wr,
    output logic [AW-1:0] ioctl_addr,
    output logic [15:0]   ioctl_dout,
    output logic          busy,
    output logic          done,
    output logic [15:0]   csum
);

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, GAP, END} state_t;

    localparam logic [3:0] GAP_LAST = (WR_GAP == 0) ? 4'd0 : 4'(WR_GAP - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] rem_q;
    logic [AW-1:0] addr_q;
    logic [15:0]   dout_q;
    logic [3:0]    gap_cnt_q;
    logic          hi_sel_q;
    logic          done_q;

    logic start_ok, accept, last_byte, gap_last, more, word_end;

    assign start_ok  = (state_q == IDLE) && start && !abort;
    assign accept    = src_ready && src_valid && !abort;
    assign last_byte = hi_sel_q || (rem_q == AW'(1));
    assign gap_last  = (gap_cnt_q == GAP_LAST);
    assign more      = (rem_q != '0);

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        word_end = 1'b0;
        case (state_q)
            IDLE:  if (start_ok && len != '0) state_d = LOAD;
            LOAD:  if (accept && last_byte) state_d = WRITE;
            WRITE: begin
                if (WR_GAP == 0) begin
                    word_end = 1'b1;
                    state_d  = more ? LOAD : END;
                end else begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_last) begin
                    word_end = 1'b1;
                    state_d  = more ? LOAD : END;
                end
            end
            END:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort overrides any transition, including a byte handshake this cycle.
        if (abort && state_q != IDLE) state_d = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            addr_q    <= '0;
            dout_q    <= '0;
            gap_cnt_q <= '0;
            hi_sel_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (start_ok && len == '0) || (state_q == END && !abort);

            if (start_ok) begin
                rem_q    <= len;
                addr_q   <= '0;
                hi_sel_q <= 1'b0;
            end

            if (accept) begin
                rem_q <= rem_q - AW'(1);
                if (!hi_sel_q) begin
                    dout_q[7:0] <= src_data;
                    if (rem_q == AW'(1)) dout_q[15:8] <= 8'h00;
                    else                 hi_sel_q     <= 1'b1;
                end else begin
                    dout_q[15:8] <= src_data;
                    hi_sel_q     <= 1'b0;
                end
            end

            if (state_q == WRITE)    gap_cnt_q <= 4'd0;
            else if (state_q == GAP) gap_cnt_q <= gap_cnt_q + 4'd1;

            if (word_end) addr_q <= addr_q + AW'(2);
        end
    end

    assign src_ready      = (state_q == LOAD);
    assign ioctl_download = (state_q != IDLE);
    assign busy           = (state_q != IDLE);
    assign ioctl_wr       = (state_q == WRITE);
    assign ioctl_addr     = addr_q;
    assign ioctl_dout     = dout_q;
    assign done           = done_q;

`ifdef JTGNG_IOCTL_CSUM_EN
    logic [15:0] csum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 csum_q <= '0;
        else if (start_ok)       csum_q <= '0;
        else if (state_q == WRITE) csum_q <= csum_q + dout_q;
    end

    assign csum = csum_q;
`else
    assign csum = 16'h0000;
`endif

endmodule

// File: tb/tb_jtgng_ioctl_tx.sv
// Scoreboard bench for jtgng_ioctl_tx: expected words are queued when a transfer is
// launched and popped by a monitor on every ioctl_wr strobe.
module tb_jtgng_ioctl_tx;

    localparam int AW     = 25;
    localparam int WR_GAP = 4;
`ifdef JTGNG_IOCTL_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] len;
    logic          abort;
    logic [7:0]    src_data;
    logic          src_valid;
    logic          src_ready;
    logic          ioctl_download;
    logic          ioctl_wr;
    logic [AW-1:0] ioctl_addr;
    logic [15:0]   ioctl_dout;
    logic          busy;
    logic          done;
    logic [15:0]   csum;

    jtgng_ioctl_tx #(.AW(AW), .WR_GAP(WR_GAP)) dut (
        .rst            (rst),
        .clk            (clk),
        .start          (start),
        .len            (len),
        .abort          (abort),
        .src_data       (src_data),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .busy           (busy),
        .done           (done),
        .csum           (csum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   dout;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] src_bytes[$];
    int         wr_cyc_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;
    bit dl_seen  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on each strobe and watches handshake legality.
    always @(negedge clk) begin
        if (!rst) begin
            if (ioctl_download) dl_seen = 1'b1;
            if (done) done_cnt++;
            if (src_ready && (!ioctl_download || ioctl_wr))
                check("ready_outside_load", 32'(src_ready), 32'd0);
            if (ioctl_wr) begin
                exp_t e;
                wr_cnt++;
                wr_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", 32'(ioctl_wr), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(ioctl_addr), 32'(e.addr));
                    check("wr_dout", 32'(ioctl_dout), 32'(e.dout));
                end
            end
        end
    end

    task automatic run_xfer(input int n, input bit toggle, input bit abort_mode, input bit start_busy);
        int          idx;
        int          d0;
        int          w0;
        int          nw;
        logic [15:0] ecs;
        logic [15:0] wd;
        idx = 0;
        d0  = done_cnt;
        w0  = wr_cnt;
        ecs = 16'h0000;
        nw  = (n + 1) / 2;
        for (int w = 0; w < nw; w++) begin
            wd[7:0]  = src_bytes[2*w];
            wd[15:8] = (2*w + 1 < n) ? src_bytes[2*w+1] : 8'h00;
            ecs      = ecs + wd;
            if (!abort_mode || w == 0) exp_q.push_back('{addr: AW'(2*w), dout: wd});
        end

        start = 1'b1;
        len   = AW'(n);
        @(posedge clk); #1;
        start = 1'b0;
        check("dl_after_start", 32'(ioctl_download), 32'd1);

        for (int c = 0; c < 400; c++) begin
            src_valid = toggle ? (c % 2 == 0) : 1'b1;
            src_data  = (idx < n) ? src_bytes[idx] : 8'hEE;
            start     = start_busy && (c == 3);
            if (start) len = AW'(2);
            @(negedge clk);
            if (src_valid && src_ready) idx++;
            @(posedge clk); #1;
            start = 1'b0;
            if (done) break;
            if (abort_mode && wr_cnt != w0) begin
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                check("abort_dl", 32'(ioctl_download), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_wr", 32'(ioctl_wr), 32'd0);
                repeat (20) @(posedge clk);
                #1;
                break;
            end
        end
        src_valid = 1'b0;

        if (abort_mode) begin
            check("abort_wr_count", 32'(wr_cnt - w0), 32'd1);
            check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        end else begin
            check("done_pulse", 32'(done), 32'd1);
            check("dl_at_done", 32'(ioctl_download), 32'd0);
            check("wr_count", 32'(wr_cnt - w0), 32'(nw));
            check("csum", 32'(csum), CSUM_EN ? 32'(ecs) : 32'd0);
            @(posedge clk); #1;
            check("done_single", 32'(done), 32'd0);
            check("done_count", 32'(done_cnt - d0), 32'd1);
        end
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int d0;
        int w0;
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        abort     = 1'b0;
        src_data  = 8'h00;
        src_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_download", 32'(ioctl_download), 32'd0);
        check("rst_wr", 32'(ioctl_wr), 32'd0);
        check("rst_ready", 32'(src_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(ioctl_addr), 32'd0);
        check("rst_dout", 32'(ioctl_dout), 32'd0);
        check("rst_csum", 32'(csum), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Even length, valid held high: two words, fixed strobe spacing.
        src_bytes = '{8'h10, 8'h83, 8'h00, 8'h80};
        wr_cyc_q.delete();
        run_xfer(4, 1'b0, 1'b0, 1'b0);
        if (wr_cyc_q.size() >= 2) check("wr_spacing", 32'(wr_cyc_q[1] - wr_cyc_q[0]), 32'(3 + WR_GAP));
        else                      check("wr_spacing_n", 32'(wr_cyc_q.size()), 32'd2);

        // Odd length: final high byte padded with zero.
        src_bytes = '{8'hAA, 8'hBB, 8'hCC};
        run_xfer(3, 1'b0, 1'b0, 1'b0);
        check("csum_literal", 32'(csum), CSUM_EN ? 32'h0000BC76 : 32'd0);

        // Zero length: done next cycle, no download, no strobe.
        d0      = done_cnt;
        w0      = wr_cnt;
        dl_seen = 1'b0;
        start   = 1'b1;
        len     = '0;
        @(posedge clk); #1;
        start = 1'b0;
        check("len0_done", 32'(done), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("len0_done_clear", 32'(done), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("len0_no_download", 32'(dl_seen), 32'd0);
        check("len0_no_wr", 32'(wr_cnt - w0), 32'd0);
        check("len0_done_count", 32'(done_cnt - d0), 32'd1);

        // Toggling src_valid, random data.
        src_bytes.delete();
        for (int i = 0; i < 8; i++) src_bytes.push_back(8'($urandom_range(0, 255)));
        run_xfer(8, 1'b1, 1'b0, 1'b0);

        // Abort in GAP after the first word, then a fresh transfer restarts at address 0.
        src_bytes.delete();
        for (int i = 0; i < 8; i++) src_bytes.push_back(8'(8'h20 + i));
        run_xfer(8, 1'b0, 1'b1, 1'b0);
        src_bytes = '{8'h5A, 8'hC3};
        run_xfer(2, 1'b0, 1'b0, 1'b0);

        // start pulsed while busy is ignored.
        src_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_xfer(4, 1'b0, 1'b0, 1'b1);

        // Reset asserted mid-LOAD: outputs take reset values without waiting for a clock.
        start     = 1'b1;
        len       = AW'(8);
        src_valid = 1'b1;
        src_data  = 8'h55;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_ready", 32'(src_ready), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_download", 32'(ioctl_download), 32'd0);
        check("arst_wr", 32'(ioctl_wr), 32'd0);
        check("arst_ready", 32'(src_ready), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_addr", 32'(ioctl_addr), 32'd0);
        check("arst_dout", 32'(ioctl_dout), 32'd0);
        check("arst_csum", 32'(csum), 32'd0);
        src_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        src_bytes = '{8'h12, 8'h34};
        run_xfer(2, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jtgng_ioctl_tx.md
JTGNG_IOCTL_TX -- requirements
Module: jtgng_ioctl_tx

Interface
REQ-001 Parameter AW, default 25, SHALL set the ioctl byte-address width.
REQ-002 Parameter WR_GAP, default 4, range 0-15, SHALL set the idle cycles inserted after every ioctl_wr strobe.
REQ-003 Port rst, input, 1 bit, SHALL be the reset: asynchronous, active-high.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all logic runs on its rising edge.
REQ-005 Port start, input, 1 bit, SHALL request a download of len bytes.
REQ-006 Port len, input, AW bits, SHALL give the transfer length in bytes, sampled only on an accepted start.
REQ-007 Port abort, input, 1 bit, SHALL cancel a transfer in progress.
REQ-008 Port src_data, input, 8 bits, SHALL carry the source byte.
REQ-009 Port src_valid, input, 1 bit, SHALL qualify src_data.
REQ-010 Port src_ready, output, 1 bit, SHALL indicate the block accepts a byte this cycle.
REQ-011 Port ioctl_download, output, 1 bit, SHALL be high for the whole transfer.
REQ-012 Port ioctl_wr, output, 1 bit, SHALL be the single-cycle word write strobe.
REQ-013 Port ioctl_addr, output, AW bits, SHALL give the byte address of the low byte of the current word.
REQ-014 Port ioctl_dout, output, 16 bits, SHALL carry the word: first byte in [7:0], second byte in [15:8].
REQ-015 Port busy, output, 1 bit, SHALL be high whenever the FSM is not in IDLE.
REQ-016 Port done, output, 1 bit, SHALL pulse for one cycle when a transfer completes.
REQ-017 Port csum, output, 16 bits, SHALL carry the word checksum (see Configuration).

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, WRITE, GAP and END.
REQ-019 In IDLE, a start with len!=0 SHALL capture len, clear ioctl_addr to 0, set ioctl_download the next cycle and enter LOAD.
REQ-020 In IDLE, a start with len==0 SHALL pulse done the next cycle, keep ioctl_download low and stay in IDLE.
REQ-021 src_ready SHALL be high only in LOAD, and a byte SHALL transfer only when src_valid and src_ready are both high.
REQ-022 In LOAD, the 1st accepted byte SHALL go to ioctl_dout[7:0] and the 2nd to [15:8]; after the 2nd byte the FSM SHALL enter WRITE.
REQ-023 If the remaining count reaches 0 after a 1st byte (odd len), ioctl_dout[15:8] SHALL be forced to 8'h00 and the FSM SHALL enter WRITE.
REQ-024 In WRITE, ioctl_wr SHALL be 1 for exactly one cycle; ioctl_addr and ioctl_dout SHALL stay stable from that cycle to the end of GAP.
REQ-025 GAP SHALL last exactly WR_GAP cycles (0 = skip GAP); on exit, ioctl_addr SHALL advance by 2, wrapping modulo 2^AW.
REQ-026 On GAP exit, the FSM SHALL go to LOAD if bytes remain, else to END.
REQ-027 With src_valid held high, one word SHALL take 3+WR_GAP cycles.
REQ-028 END SHALL last one cycle with ioctl_download still high; on the next cycle ioctl_download SHALL be 0, done SHALL be 1, and the FSM SHALL be in IDLE.
REQ-029 start SHALL be ignored while busy.
REQ-030 abort SHALL, in any state other than IDLE, return the FSM to IDLE with ioctl_download=0 and ioctl_wr=0 on the next cycle, with no done pulse.
REQ-031 abort SHALL take priority over start and over a simultaneous byte handshake; a byte accepted in the same cycle as abort SHALL be discarded.
REQ-032 In the same cycle, start SHALL be accepted only if abort is low.

Reset
REQ-033 rst SHALL asynchronously force IDLE and set ioctl_download, ioctl_wr, src_ready, busy and done to 0, ioctl_addr to 0, ioctl_dout to 0 and csum to 0.
REQ-034 A reset asserted mid-transfer SHALL behave as abort, except that all outputs take their reset values immediately.

Configuration
REQ-035 With JTGNG_IOCTL_CSUM_EN defined, csum SHALL clear on an accepted start and add each written ioctl_dout modulo 2^16 in its WRITE cycle; it SHALL be valid when done pulses and held until the next start.
REQ-036 Without JTGNG_IOCTL_CSUM_EN, csum SHALL be constant 0 and no adder logic SHALL be built.

Verification
REQ-037 WR_GAP=4, len=4, bytes 10 83 00 80 with src_valid held high -> ioctl_wr at addr 0 with dout 8310, then at addr 2 with dout 8000; strobes 7 cycles apart; one done pulse.
REQ-038 len=3, bytes AA BB CC -> second word is 00CC at addr 2; with the macro, csum = 00CC+BBAA = BC76.
REQ-039 len=0 start -> done high one cycle later; ioctl_download never rises; no ioctl_wr.
REQ-040 src_valid toggling 1/0 every cycle, len=8 -> exactly 4 strobes at addrs 0,2,4,6; data intact; no byte accepted outside LOAD.
REQ-041 abort asserted in GAP after the 1st word of len=8 -> ioctl_download low next cycle; no further ioctl_wr; no done; a new start then begins at addr 0.
REQ-042 start pulsed while busy, and rst asserted mid-LOAD -> start ignored; on rst, all outputs at reset values within the same cycle.
